// File: rtl/qbert_pkg.sv
// Shared types and constants for the Q*bert pyramid renderer.
//   rgb_t          : packed 8/8/8 pixel colour
//   scan_state_t   : landing-scan FSM encoding
//   *_RGB          : palette used by the pixel colour stage
//   cube_base()    : flat index of the first cube of a rank (rank-major order)
package qbert_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        UPDATE = 2'd2
    } scan_state_t;

    localparam rgb_t QBERT_RGB      = '{r: 8'd216, g: 8'd95,  b: 8'd2};
    localparam rgb_t LEFT_RGB       = '{r: 8'd86,  g: 8'd169, b: 8'd152};
    localparam rgb_t RIGHT_RGB      = '{r: 8'd49,  g: 8'd70,  b: 8'd70};
    localparam rgb_t TOP_START_RGB  = '{r: 8'd86,  g: 8'd70,  b: 8'd239};
    localparam rgb_t TOP_MID_RGB    = '{r: 8'd239, g: 8'd70,  b: 8'd150};
    localparam rgb_t TOP_TARGET_RGB = '{r: 8'd222, g: 8'd222, b: 8'd0};
    localparam rgb_t BLACK_RGB      = '{r: 8'd0,   g: 8'd0,   b: 8'd0};

    // Rank r holds n-r cubes, so it starts after sum_{j<r}(n-j) cubes.
    // Elaboration-time only.
    function automatic int cube_base(input int r, input int n);
        return r * n - (r * (r - 1)) / 2;
    endfunction

endpackage

// File: rtl/qbert_pyramid_renderer_if.sv
// Bus between the MTL/game logic (master) and the pyramid renderer (slave).
//   master drives : qbert_jump, Qbert box bounds, map geometry, level_clear,
//                   x_cnt/y_cnt pixel counters
//   slave drives  : red/green/blue, landed_valid/landed_idx, fell_off,
//                   cubes_done, level_done
interface qbert_pyramid_renderer_if #(parameter int N_RANKS = 3);

    localparam int NCUBES = N_RANKS * (N_RANKS + 1) / 2;
    localparam int IW     = (NCUBES > 1) ? $clog2(NCUBES) : 1;
    localparam int DW     = $clog2(NCUBES + 1);

    logic          qbert_jump;
    logic [10:0]   QBERT_POSITION_X0, QBERT_POSITION_X1;
    logic [9:0]    QBERT_POSITION_Y0, QBERT_POSITION_Y1;
    logic [10:0]   XLENGTH, XDIAG_DEMI, RANK1_X_OFFSET;
    logic [9:0]    YDIAG_DEMI, RANK1_Y_OFFSET;
    logic          level_clear;
    logic [10:0]   x_cnt;
    logic [9:0]    y_cnt;
    logic [7:0]    red, green, blue;
    logic          landed_valid;
    logic [IW-1:0] landed_idx;
    logic          fell_off;
    logic [DW-1:0] cubes_done;
    logic          level_done;

    modport master (
        output qbert_jump, QBERT_POSITION_X0, QBERT_POSITION_X1,
               QBERT_POSITION_Y0, QBERT_POSITION_Y1, XLENGTH, XDIAG_DEMI,
               RANK1_X_OFFSET, YDIAG_DEMI, RANK1_Y_OFFSET, level_clear,
               x_cnt, y_cnt,
        input  red, green, blue, landed_valid, landed_idx, fell_off,
               cubes_done, level_done
    );

    modport slave (
        input  qbert_jump, QBERT_POSITION_X0, QBERT_POSITION_X1,
               QBERT_POSITION_Y0, QBERT_POSITION_Y1, XLENGTH, XDIAG_DEMI,
               RANK1_X_OFFSET, YDIAG_DEMI, RANK1_Y_OFFSET, level_clear,
               x_cnt, y_cnt,
        output red, green, blue, landed_valid, landed_idx, fell_off,
               cubes_done, level_done
    );

endinterface

// File: rtl/cube_generator.sv
// Face hit test for one isometric cube (pixel stage S1, registered).
//   clk_i, rst_i          : clock, synchronous active-high reset
//   x_cnt_i, y_cnt_i      : current pixel
//   x_off_i, y_off_i      : cube origin
//   xlength_i, xdiag_i, ydiag_i : cube geometry
//   left_o, right_o, top_o: registered face hits
// The cube spans dx in [0, XLENGTH+2*XDIAG] and dy in [0, 2*YDIAG] from its
// origin. The side band dx < XLENGTH is split at dy = YDIAG into the left and
// right faces; the rest of the span is the top face. Offsets are taken
// modulo the counter width, so a pixel "before" the origin wraps to a large
// value and misses every range compare.
module cube_generator (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [10:0] x_cnt_i,
    input  logic [9:0]  y_cnt_i,
    input  logic [10:0] x_off_i,
    input  logic [9:0]  y_off_i,
    input  logic [10:0] xlength_i,
    input  logic [10:0] xdiag_i,
    input  logic [9:0]  ydiag_i,
    output logic        left_o,
    output logic        right_o,
    output logic        top_o
);

    logic [10:0] dx, top_end;
    logic [9:0]  dy, ydiag2;
    logic        side, left_d, right_d, top_d;
    logic        left_q, right_q, top_q;

    assign dx      = x_cnt_i - x_off_i;
    assign dy      = y_cnt_i - y_off_i;
    assign top_end = xlength_i + xdiag_i + xdiag_i;
    assign ydiag2  = ydiag_i + ydiag_i;
    assign side    = dx < xlength_i;
    assign left_d  = side && (dy < ydiag_i);
    assign right_d = side && (dy >= ydiag_i) && (dy <= ydiag2);
    assign top_d   = (dx >= xlength_i) && (dx <= top_end) && (dy <= ydiag2);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            left_q  <= 1'b0;
            right_q <= 1'b0;
            top_q   <= 1'b0;
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
            top_q   <= top_d;
        end
    end

    assign left_o  = left_q;
    assign right_o = right_q;
    assign top_o   = top_q;

endmodule

// File: rtl/qbert_pyramid_renderer.sv
// N_RANKS-deep Q*bert pyramid renderer with per-cube hit state.
//   CLK_33 : pixel clock
//   reset  : synchronous, active-high
//   bus    : slave side of qbert_pyramid_renderer_if (pixel counters, Qbert
//            box, geometry, level_clear in; rgb and landing status out)
// Pixel path: S1 cube face hits, S2 face OR + top-face owner, S3 colour.
// Landing path: on each falling edge of qbert_jump, scan the cubes one per
// cycle for the one under the Qbert box centre and bump its hit state.
module qbert_pyramid_renderer
    import qbert_pkg::*;
#(
    parameter int N_RANKS     = 3,
    parameter int HIT_LEVELS  = 1,
    parameter int REVERT_MODE = 0
) (
    input  logic                     CLK_33,
    input  logic                     reset,
    qbert_pyramid_renderer_if.slave  bus
);

    localparam int NCUBES = N_RANKS * (N_RANKS + 1) / 2;
    localparam int IW     = (NCUBES > 1) ? $clog2(NCUBES) : 1;
    localparam int DW     = $clog2(NCUBES + 1);
    localparam logic [1:0] HL        = 2'(HIT_LEVELS);
    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_SCAN   = 2'(SCAN);
    localparam logic [1:0] ST_UPDATE = 2'(UPDATE);

    // ---------------- geometry (products by repeated addition) ----------------
    logic [10:0] xstep;
    logic [9:0]  ystep;
    logic [10:0] rank_x [N_RANKS];
    logic [9:0]  rank_y [N_RANKS];
    logic [9:0]  kofs   [N_RANKS];
    logic [10:0] cube_x [NCUBES], cube_cx [NCUBES];
    logic [9:0]  cube_y [NCUBES], cube_cy [NCUBES];
    logic [NCUBES-1:0] left_s1, right_s1, top_s1;

    always_comb begin
        xstep     = bus.XLENGTH + bus.XDIAG_DEMI + 11'd1;
        ystep     = bus.YDIAG_DEMI + bus.YDIAG_DEMI + 10'd1;
        rank_x[0] = bus.RANK1_X_OFFSET;
        rank_y[0] = bus.RANK1_Y_OFFSET;
        kofs[0]   = '0;
        for (int r = 1; r < N_RANKS; r++) begin
            rank_x[r] = rank_x[r-1] - xstep;
            rank_y[r] = rank_y[r-1] + bus.YDIAG_DEMI;
            kofs[r]   = kofs[r-1] + ystep;
        end
    end

    for (genvar r = 0; r < N_RANKS; r++) begin : g_rank
        for (genvar k = 0; k < N_RANKS - r; k++) begin : g_pos
            localparam int I = cube_base(r, N_RANKS) + k;
            assign cube_x[I]  = rank_x[r];
            assign cube_y[I]  = rank_y[r] + kofs[k];
            assign cube_cx[I] = rank_x[r] + bus.XLENGTH + bus.XDIAG_DEMI;
            assign cube_cy[I] = rank_y[r] + kofs[k] + bus.YDIAG_DEMI;
            cube_generator u_cube (
                .clk_i     (CLK_33),
                .rst_i     (reset),
                .x_cnt_i   (bus.x_cnt),
                .y_cnt_i   (bus.y_cnt),
                .x_off_i   (cube_x[I]),
                .y_off_i   (cube_y[I]),
                .xlength_i (bus.XLENGTH),
                .xdiag_i   (bus.XDIAG_DEMI),
                .ydiag_i   (bus.YDIAG_DEMI),
                .left_o    (left_s1[I]),
                .right_o   (right_s1[I]),
                .top_o     (top_s1[I])
            );
        end
    end

    // ---------------- pixel pipeline S2/S3 ----------------
    logic          qb_hit;
    logic [1:0]    qb_pipe_q;           // Qbert box hit aligned to S3
    logic          is_left_q, is_right_q, is_top_q;
    logic [IW-1:0] owner_d, owner_q;
    logic [1:0]    hit_q [NCUBES];
    logic [1:0]    hit_d [NCUBES];
    logic [1:0]    top_st;
    rgb_t          top_rgb, rgb_d, rgb_q;

    assign qb_hit = (bus.x_cnt >= bus.QBERT_POSITION_X0) && (bus.x_cnt <= bus.QBERT_POSITION_X1) &&
                    (bus.y_cnt >= bus.QBERT_POSITION_Y0) && (bus.y_cnt <= bus.QBERT_POSITION_Y1);

    // Faces never overlap within a cube, but tops of neighbours can touch;
    // the lowest index wins.
    always_comb begin
        owner_d = '0;
        for (int i = NCUBES - 1; i >= 0; i--)
            if (top_s1[i]) owner_d = IW'(i);
    end

    always_comb begin
        top_st = hit_q[owner_q];
        if (top_st == 2'd0)    top_rgb = TOP_START_RGB;
        else if (top_st == HL) top_rgb = TOP_TARGET_RGB;
        else                   top_rgb = TOP_MID_RGB;
        if (qb_pipe_q[1])    rgb_d = QBERT_RGB;
        else if (is_left_q)  rgb_d = LEFT_RGB;
        else if (is_right_q) rgb_d = RIGHT_RGB;
        else if (is_top_q)   rgb_d = top_rgb;
        else                 rgb_d = BLACK_RGB;
    end

    // ---------------- landing FSM ----------------
    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, landed_idx_q, landed_idx_d;
    logic [10:0]   qx_q, qx_d, dxs, adx;
    logic [9:0]    qy_q, qy_d, dys, ady;
    logic          pend_q, pend_d, jump_q, land, scan_hit;
    logic          landed_valid_q, landed_valid_d, fell_off_q, fell_off_d;
    logic [DW-1:0] cubes_done_q, cubes_done_d;
    logic [1:0]    cur, nxt;

    assign land     = jump_q && !bus.qbert_jump;
    assign dxs      = qx_q - cube_cx[idx_q];
    assign dys      = qy_q - cube_cy[idx_q];
    assign adx      = dxs[10] ? (11'd0 - dxs) : dxs;
    assign ady      = dys[9]  ? (10'd0 - dys) : dys;
    assign scan_hit = (adx <= bus.XDIAG_DEMI) && (ady <= bus.YDIAG_DEMI);
    assign cur      = hit_q[idx_q];
    assign nxt      = (cur == HL) ? ((REVERT_MODE != 0) ? cur - 2'd1 : cur) : cur + 2'd1;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        qx_d           = qx_q;
        qy_d           = qy_q;
        pend_d         = pend_q;
        hit_d          = hit_q;
        cubes_done_d   = cubes_done_q;
        landed_valid_d = 1'b0;
        landed_idx_d   = landed_idx_q;
        fell_off_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A pending landing is taken first; an edge arriving in the
                // same cycle is dropped because the single slot is full.
                if (pend_q || land) begin
                    pend_d  = 1'b0;
                    qx_d    = 11'(({1'b0, bus.QBERT_POSITION_X0} + {1'b0, bus.QBERT_POSITION_X1}) >> 1);
                    qy_d    = 10'(({1'b0, bus.QBERT_POSITION_Y0} + {1'b0, bus.QBERT_POSITION_Y1}) >> 1);
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (land) pend_d = 1'b1;
                if (scan_hit) begin
                    state_d = ST_UPDATE;
                end else if (idx_q == IW'(NCUBES - 1)) begin
                    fell_off_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_UPDATE: begin
                if (land) pend_d = 1'b1;
                hit_d[idx_q] = nxt;
                if (cur != HL && nxt == HL)      cubes_done_d = cubes_done_q + DW'(1);
                else if (cur == HL && nxt != HL) cubes_done_d = cubes_done_q - DW'(1);
                landed_valid_d = 1'b1;
                landed_idx_d   = idx_q;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.level_clear) begin
            for (int i = 0; i < NCUBES; i++) hit_d[i] = 2'd0;
            cubes_done_d   = '0;
            pend_d         = 1'b0;
            landed_valid_d = 1'b0;
            fell_off_d     = 1'b0;
            state_d        = ST_IDLE;
        end
    end

    always_ff @(posedge CLK_33) begin
        if (reset) begin
            qb_pipe_q      <= '0;
            is_left_q      <= 1'b0;
            is_right_q     <= 1'b0;
            is_top_q       <= 1'b0;
            owner_q        <= '0;
            rgb_q          <= BLACK_RGB;
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            qx_q           <= '0;
            qy_q           <= '0;
            pend_q         <= 1'b0;
            jump_q         <= 1'b0;
            for (int i = 0; i < NCUBES; i++) hit_q[i] <= 2'd0;
            cubes_done_q   <= '0;
            landed_valid_q <= 1'b0;
            landed_idx_q   <= '0;
            fell_off_q     <= 1'b0;
        end else begin
            qb_pipe_q      <= {qb_pipe_q[0], qb_hit};
            is_left_q      <= |left_s1;
            is_right_q     <= |right_s1;
            is_top_q       <= |top_s1;
            owner_q        <= owner_d;
            rgb_q          <= rgb_d;
            state_q        <= state_d;
            idx_q          <= idx_d;
            qx_q           <= qx_d;
            qy_q           <= qy_d;
            pend_q         <= pend_d;
            jump_q         <= bus.qbert_jump;
            hit_q          <= hit_d;
            cubes_done_q   <= cubes_done_d;
            landed_valid_q <= landed_valid_d;
            landed_idx_q   <= landed_idx_d;
            fell_off_q     <= fell_off_d;
        end
    end

    assign bus.red          = rgb_q.r;
    assign bus.green        = rgb_q.g;
    assign bus.blue         = rgb_q.b;
    assign bus.landed_valid = landed_valid_q;
    assign bus.landed_idx   = landed_idx_q;
    assign bus.fell_off     = fell_off_q;
    assign bus.cubes_done   = cubes_done_q;
    assign bus.level_done   = (cubes_done_q == DW'(NCUBES));

endmodule

// File: tb/tb_qbert_pyramid_renderer.sv
// Directed bench for qbert_pyramid_renderer. Three instances share one
// stimulus stream: A (defaults), B (REVERT_MODE=1), C (HIT_LEVELS=2).
module tb_qbert_pyramid_renderer;

    localparam logic [23:0] C_START  = 24'h5646EF;
    localparam logic [23:0] C_MID    = 24'hEF4696;
    localparam logic [23:0] C_TARGET = 24'hDEDE00;
    localparam logic [23:0] C_LEFT   = 24'h56A998;
    localparam logic [23:0] C_RIGHT  = 24'h314646;
    localparam logic [23:0] C_QBERT  = 24'hD85F02;
    localparam logic [23:0] C_BLACK  = 24'h000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, jump, lclr;
    logic [10:0] bx0, bx1, xc;
    logic [9:0]  by0, by1, yc;

    qbert_pyramid_renderer_if ifa ();
    qbert_pyramid_renderer_if ifb ();
    qbert_pyramid_renderer_if ifc ();

    assign ifa.qbert_jump = jump; assign ifa.level_clear = lclr; assign ifa.x_cnt = xc; assign ifa.y_cnt = yc;
    assign ifa.QBERT_POSITION_X0 = bx0; assign ifa.QBERT_POSITION_X1 = bx1;
    assign ifa.QBERT_POSITION_Y0 = by0; assign ifa.QBERT_POSITION_Y1 = by1;
    assign ifa.XLENGTH = 11'd55; assign ifa.XDIAG_DEMI = 11'd30; assign ifa.YDIAG_DEMI = 10'd50;
    assign ifa.RANK1_X_OFFSET = 11'd600; assign ifa.RANK1_Y_OFFSET = 10'd90;
    assign ifb.qbert_jump = jump; assign ifb.level_clear = lclr; assign ifb.x_cnt = xc; assign ifb.y_cnt = yc;
    assign ifb.QBERT_POSITION_X0 = bx0; assign ifb.QBERT_POSITION_X1 = bx1;
    assign ifb.QBERT_POSITION_Y0 = by0; assign ifb.QBERT_POSITION_Y1 = by1;
    assign ifb.XLENGTH = 11'd55; assign ifb.XDIAG_DEMI = 11'd30; assign ifb.YDIAG_DEMI = 10'd50;
    assign ifb.RANK1_X_OFFSET = 11'd600; assign ifb.RANK1_Y_OFFSET = 10'd90;
    assign ifc.qbert_jump = jump; assign ifc.level_clear = lclr; assign ifc.x_cnt = xc; assign ifc.y_cnt = yc;
    assign ifc.QBERT_POSITION_X0 = bx0; assign ifc.QBERT_POSITION_X1 = bx1;
    assign ifc.QBERT_POSITION_Y0 = by0; assign ifc.QBERT_POSITION_Y1 = by1;
    assign ifc.XLENGTH = 11'd55; assign ifc.XDIAG_DEMI = 11'd30; assign ifc.YDIAG_DEMI = 10'd50;
    assign ifc.RANK1_X_OFFSET = 11'd600; assign ifc.RANK1_Y_OFFSET = 10'd90;

    qbert_pyramid_renderer #(.N_RANKS(3), .HIT_LEVELS(1), .REVERT_MODE(0)) dut_a (.CLK_33(clk), .reset(rst), .bus(ifa));
    qbert_pyramid_renderer #(.N_RANKS(3), .HIT_LEVELS(1), .REVERT_MODE(1)) dut_b (.CLK_33(clk), .reset(rst), .bus(ifb));
    qbert_pyramid_renderer #(.N_RANKS(3), .HIT_LEVELS(2), .REVERT_MODE(0)) dut_c (.CLK_33(clk), .reset(rst), .bus(ifc));

    int errs = 0;
    int nchk = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] rgb_a();
        return {ifa.red, ifa.green, ifa.blue};
    endfunction
    function automatic logic [23:0] rgb_b();
        return {ifb.red, ifb.green, ifb.blue};
    endfunction
    function automatic logic [23:0] rgb_c();
        return {ifc.red, ifc.green, ifc.blue};
    endfunction

    task automatic set_box(input int cx, input int cy);
        bx0 = 11'(cx - 10); bx1 = 11'(cx + 10);
        by0 = 10'(cy - 10); by1 = 10'(cy + 10);
    endtask

    task automatic pix(input int x, input int y);
        @(negedge clk);
        bx0 = 11'd2000; bx1 = 11'd2000; by0 = 10'd1000; by1 = 10'd1000;
        xc = 11'(x); yc = 10'(y);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // res: 1 = landed_valid seen, 2 = fell_off seen, 0 = neither (timeout)
    task automatic land(input int cx, input int cy, output int res, output int idx, output int cyc);
        @(negedge clk);
        set_box(cx, cy);
        jump = 1'b1;
        @(negedge clk);
        jump = 1'b0;
        res = 0; idx = -1; cyc = 0;
        for (int i = 1; i <= 20 && res == 0; i++) begin
            @(posedge clk); #1;
            cyc = i;
            if (ifa.landed_valid) begin res = 1; idx = int'(ifa.landed_idx); end
            else if (ifa.fell_off) res = 2;
        end
    endtask

    task automatic watch(input int n, output int nv, output int nf, output int li);
        nv = 0; nf = 0; li = -1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (ifa.landed_valid) begin nv++; li = int'(ifa.landed_idx); end
            if (ifa.fell_off) nf++;
        end
    endtask

    typedef struct { int x0, x1, y0, y1, x, y; logic [23:0] rgb; } pv_t;
    typedef struct { int cx, cy, res, idx, da, db, dc; } lv_t;

    pv_t pv [11];
    lv_t lt [8];
    int  res, idx, cyc, nv, nf, li;

    initial begin
        pv[0]  = '{2000, 2000, 1000, 1000, 685, 140, C_START};  // cube 0 top centre
        pv[1]  = '{2000, 2000, 1000, 1000, 715, 140, C_START};  // top far edge
        pv[2]  = '{2000, 2000, 1000, 1000, 716, 140, C_BLACK};  // one past
        pv[3]  = '{2000, 2000, 1000, 1000, 620, 110, C_LEFT};
        pv[4]  = '{2000, 2000, 1000, 1000, 620, 170, C_RIGHT};  // beats cube 3 top
        pv[5]  = '{2000, 2000, 1000, 1000, 599, 190, C_START};  // cube 3 top
        pv[6]  = '{2000, 2000, 1000, 1000, 520, 160, C_LEFT};   // cube 3 left
        pv[7]  = '{2000, 2000, 1000, 1000, 100, 100, C_BLACK};
        pv[8]  = '{675, 695, 130, 150, 685, 140, C_QBERT};
        pv[9]  = '{675, 695, 130, 150, 674, 140, C_START};
        pv[10] = '{675, 695, 130, 150, 695, 150, C_QBERT};

        lt[0] = '{685, 140, 1, 0, 1, 1, 0};
        lt[1] = '{599, 190, 1, 3, 2, 2, 0};
        lt[2] = '{100, 100, 2, 0, 2, 2, 0};
        lt[3] = '{685, 241, 1, 1, 3, 3, 0};
        lt[4] = '{685, 342, 1, 2, 4, 4, 0};
        lt[5] = '{599, 291, 1, 4, 5, 5, 0};
        lt[6] = '{513, 240, 1, 5, 6, 6, 0};
        lt[7] = '{685, 140, 1, 0, 6, 5, 1};     // re-land: A saturates, B reverts, C reaches target

        rst = 1'b1; jump = 1'b0; lclr = 1'b0; xc = '0; yc = '0;
        bx0 = 11'd2000; bx1 = 11'd2000; by0 = 10'd1000; by1 = 10'd1000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", int'(rgb_a()), int'(C_BLACK));
        chk("rst_valid", int'(ifa.landed_valid), 0);
        chk("rst_fell", int'(ifa.fell_off), 0);
        chk("rst_done", int'(ifa.cubes_done), 0);
        chk("rst_lvl", int'(ifa.level_done), 0);
        @(negedge clk);
        rst = 1'b0;

        // exact three-cycle pixel latency
        pix(100, 100);
        @(negedge clk);
        xc = 11'd685; yc = 10'd140;
        repeat (2) @(posedge clk);
        #1 chk("lat_t2", int'(rgb_a()), int'(C_BLACK));
        @(posedge clk);
        #1 chk("lat_t3", int'(rgb_a()), int'(C_START));

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bx0 = 11'(pv[i].x0); bx1 = 11'(pv[i].x1); by0 = 10'(pv[i].y0); by1 = 10'(pv[i].y1);
            xc = 11'(pv[i].x); yc = 10'(pv[i].y);
            repeat (3) @(posedge clk);
            #1 chk($sformatf("pix%0d", i), int'(rgb_a()), int'(pv[i].rgb));
        end

        for (int i = 0; i < 8; i++) begin
            land(lt[i].cx, lt[i].cy, res, idx, cyc);
            chk($sformatf("land%0d_res", i), res, lt[i].res);
            if (lt[i].res == 1) chk($sformatf("land%0d_idx", i), idx, lt[i].idx);
            if (i == 0) chk("land0_within7", int'(cyc <= 7), 1);
            chk($sformatf("land%0d_doneA", i), int'(ifa.cubes_done), lt[i].da);
            chk($sformatf("land%0d_doneB", i), int'(ifb.cubes_done), lt[i].db);
            chk($sformatf("land%0d_doneC", i), int'(ifc.cubes_done), lt[i].dc);
            chk($sformatf("land%0d_lvlA", i), int'(ifa.level_done), int'(lt[i].da == 6));
            chk($sformatf("land%0d_lvlB", i), int'(ifb.level_done), int'(lt[i].db == 6));
        end

        pix(685, 140);
        chk("top0_A", int'(rgb_a()), int'(C_TARGET));
        chk("top0_B", int'(rgb_b()), int'(C_START));
        chk("top0_C", int'(rgb_c()), int'(C_TARGET));
        pix(599, 190);
        chk("top3_A", int'(rgb_a()), int'(C_TARGET));
        chk("top3_C", int'(rgb_c()), int'(C_MID));

        // level_clear while idle
        @(negedge clk); lclr = 1'b1;
        @(negedge clk); lclr = 1'b0;
        chk("clr_doneA", int'(ifa.cubes_done), 0);
        chk("clr_doneC", int'(ifc.cubes_done), 0);
        chk("clr_lvlA", int'(ifa.level_done), 0);
        pix(599, 190);
        chk("clr_top3_A", int'(rgb_a()), int'(C_START));

        // second landing during the scan of the first: serviced afterwards
        @(negedge clk); set_box(599, 190); jump = 1'b1;
        @(negedge clk); jump = 1'b0;
        @(negedge clk); jump = 1'b1;
        @(negedge clk); jump = 1'b0;
        watch(30, nv, nf, li);
        chk("dbl_pulses", nv, 2);
        chk("dbl_idx", li, 3);
        chk("dbl_fell", nf, 0);
        chk("dbl_doneA", int'(ifa.cubes_done), 1);
        chk("dbl_doneB", int'(ifb.cubes_done), 0);
        chk("dbl_doneC", int'(ifc.cubes_done), 1);

        // level_clear in the middle of a scan suppresses the pulse
        @(negedge clk); set_box(513, 240); jump = 1'b1;
        @(negedge clk); jump = 1'b0;
        watch(3, nv, nf, li);
        res = nv + nf;
        @(negedge clk); lclr = 1'b1;
        @(negedge clk); lclr = 1'b0;
        watch(15, nv, nf, li);
        chk("mclr_pulses", res + nv + nf, 0);
        chk("mclr_doneA", int'(ifa.cubes_done), 0);
        chk("mclr_doneC", int'(ifc.cubes_done), 0);
        pix(599, 190);
        chk("mclr_top3_A", int'(rgb_a()), int'(C_START));

        // reset in the middle of a scan
        land(685, 140, res, idx, cyc);
        chk("pre_rst_doneA", int'(ifa.cubes_done), 1);
        @(negedge clk); set_box(513, 240); jump = 1'b1; xc = 11'd685; yc = 10'd140;
        @(negedge clk); jump = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_rgb", int'(rgb_a()), int'(C_BLACK));
        chk("mrst_valid", int'(ifa.landed_valid), 0);
        chk("mrst_fell", int'(ifa.fell_off), 0);
        chk("mrst_doneA", int'(ifa.cubes_done), 0);
        chk("mrst_lvl", int'(ifa.level_done), 0);
        @(negedge clk); rst = 1'b0;
        watch(2, nv, nf, li);
        res = nv + nf;
        chk("mrst_refill2", int'(rgb_a()), int'(C_BLACK));
        watch(1, nv, nf, li);
        res = res + nv + nf;
        chk("mrst_refill3", int'(rgb_a()), int'(C_START));
        watch(12, nv, nf, li);
        chk("mrst_idle", res + nv + nf, 0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/qbert_pyramid_renderer.md
Name: qbert_pyramid_renderer

Overview:
Parametrised successor of the 6-cube Q*bert map renderer. It draws an N_RANKS-deep pyramid of isometric cubes and overlays the Qbert box on the MTL pixel stream. It also keeps a per-cube hit state that recolours each top face when Qbert lands on it. On every landing it runs a scan state machine that finds the landed cube, counts completed cubes and flags level completion or a fall-off.

Parameters:
N_RANKS, 3, pyramid ranks; NCUBES = N_RANKS*(N_RANKS+1)/2 (localparam)
HIT_LEVELS, 1, landings needed to move a top face from start colour to target colour (1..3)
REVERT_MODE, 0, 1 = landing on a cube already at target decrements its hit state (no wrap below 0)

Ports:
CLK_33  in  1  pixel clock
reset  in  1  synchronous, active-high
qbert_jump  in  1  high while Qbert is airborne
QBERT_POSITION_X0/X1  in  11  Qbert box x bounds (X0<=X1)
QBERT_POSITION_Y0/Y1  in  10  Qbert box y bounds (Y0<=Y1)
XLENGTH, XDIAG_DEMI, RANK1_X_OFFSET  in  11  map geometry
YDIAG_DEMI, RANK1_Y_OFFSET  in  10  map geometry
level_clear  in  1  one-cycle pulse; all hit states return to 0
x_cnt  in  11 ; y_cnt  in  10  MTL pixel counters
red, green, blue  out  8 each  pixel colour
landed_valid  out  1  one-cycle pulse after a scan hit
landed_idx  out  $clog2(NCUBES)  index of the cube that was hit
fell_off  out  1  one-cycle pulse after a scan miss
cubes_done  out  $clog2(NCUBES+1)  number of cubes at target
level_done  out  1  high while cubes_done==NCUBES

Behaviour:
- Reset: all outputs 0, rgb black, all hit states 0, FSM in IDLE, pending cleared, jump-edge register cleared to 0.
- Geometry, with rank r in 0..N_RANKS-1 and position k in 0..N_RANKS-1-r:
  - x_off = RANK1_X_OFFSET - r*(XLENGTH+XDIAG_DEMI+1)
  - y_off = RANK1_Y_OFFSET + r*YDIAG_DEMI + k*(2*YDIAG_DEMI+1)
  - Cube index = rank-major, k-minor.
  - All arithmetic is modulo 11/10 bits. Products are formed by repeated addition in generate loops; no multipliers.
- Pixel path latency is exactly 3 cycles from x_cnt/y_cnt to rgb:
  - S1 registers the face hits from each cube.
  - S2 ORs them into is_left, is_right and is_top, and records which cube owns the top face.
  - S3 selects the colour.
- Qbert-box hit (X0<=x_cnt<=X1 and Y0<=y_cnt<=Y1) is delayed to align with S3.
- Colour priority: Qbert (216,95,2) > left face (86,169,152) > right face (49,70,70) > top face > black.
- Top face colour by hit state:
  - 0 = (86,70,239)
  - HIT_LEVELS = (222,222,0)
  - intermediate states = (239,70,150)
- Landing is the falling edge of qbert_jump (registered previous value 1, current 0).
- FSM:
  - IDLE: on a landing, latch qx=(X0+X1)>>1 and qy=(Y0+Y1)>>1 using 12/11-bit sums, set idx=0, go to SCAN.
  - SCAN: tests one cube per cycle against its centre cx = x_off+XLENGTH+XDIAG_DEMI, cy = y_off+YDIAG_DEMI. A hit needs |qx-cx|<=XDIAG_DEMI and |qy-cy|<=YDIAG_DEMI.
  - SCAN, first hit: go to UPDATE. No hit after idx NCUBES-1: pulse fell_off, go to IDLE.
  - UPDATE: hit state saturates up at HIT_LEVELS. With REVERT_MODE=1, a cube already at target decrements instead. Update cubes_done, pulse landed_valid with landed_idx, go to IDLE.
- Scan takes at most NCUBES+1 cycles.
- Landing during SCAN/UPDATE sets a single pending flag. IDLE services pending before any new edge. A further landing while pending is set is dropped.
- level_clear in any state: hit states cleared, cubes_done=0, pending cleared, FSM to IDLE. No pulse is emitted that cycle; it has priority over UPDATE.
- level_done is combinational from the cubes_done register. It stays high until level_clear or reset.
- Geometry inputs must be stable during a scan; changing them is undefined for that scan only.

Decomposition:
- Package qbert_pkg: colour constants (QBERT_RGB, LEFT_RGB, RIGHT_RGB, TOP_START_RGB, TOP_MID_RGB, TOP_TARGET_RGB), rgb_t struct, scan_state_t enum {IDLE, SCAN, UPDATE}.
- One sub-module: existing cube_generator, instantiated NCUBES times in a generate loop. The landing FSM stays in the top module.

Test Plan:
- Defaults, geometry 55/30/50/600/90: pixel (x_cnt,y_cnt) inside cube 0's top face at t -> rgb (86,70,239) at t+3; pixel outside all cubes -> (0,0,0).
- Box X 675..695, Y 130..150, jump 1->0 -> landed_valid with landed_idx=0 within 7 cycles, cubes_done=1, cube 0 top (222,222,0).
- Box centred (599,190) (rank1 cube0, idx 3) -> landed_idx=3; box centred (100,100) -> fell_off pulse, cubes_done unchanged.
- Land on all 6 cubes -> level_done=1 after 6th; REVERT_MODE=1 re-land idx 0 -> cubes_done=5, level_done=0; HIT_LEVELS=2 first landing -> (239,70,150).
- Second jump edge mid-SCAN -> serviced after first (two landed_valid pulses); level_clear mid-SCAN -> no pulse, all tops (86,70,239).
- reset asserted mid-SCAN for 1 cycle -> next cycle all outputs 0, FSM IDLE, rgb black until pipeline refills.
